pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Game sequencer for the pong datapath. It owns the ball object's position and velocity, detects wall and paddle collisions against the two paddle positions from the potentiometer scaling logic, keeps score, and runs the IDLE/SERVE/PLAY/DONE game state machine. Its outputs drive the ball object's X/Y registers, the score SSD digits and the LEDs in the top level.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 10, ball width and height
PADDLE_W, 10, paddle width
PADDLE_H, 50, paddle height
P1_X, 20, left paddle X (player 1)
P2_X, 620, right paddle X (player 2)
BALL_START_X, 315, serve X
BALL_START_Y, 235, serve Y
BALL_STEP, 2, pixels moved per tick on each axis
MAX_STEP, 6, step ceiling (optional feature only)
WIN_SCORE, 9, score that ends the game
SERVE_TICKS, 60, ticks spent in SERVE before PLAY

Ports:
clk  in  1  system clock (DIV_CLK[1] domain)
reset  in  1  asynchronous, active-low reset
tick  in  1  one-clk update strobe, once per frame
start  in  1  level; starts a game from IDLE or DONE
paddle1_y  in  10  left paddle top Y, 0..430
paddle2_y  in  10  right paddle top Y, 0..430
ball_x  out  11  ball left X
ball_y  out  10  ball top Y
p1_score  out  4  player 1 score
p2_score  out  4  player 2 score
state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 DONE
point_p1  out  1  one-clk pulse when player 1 scores
point_p2  out  1  one-clk pulse when player 2 scores

Behaviour:
- Reset (reset=0, asynchronous): ball=(BALL_START_X, BALL_START_Y); scores 0; state IDLE; dir_x=1 (right); dir_y=1 (down); step=BALL_STEP; serve counter 0; point pulses 0. Reset takes effect mid-game regardless of tick.
- All outputs are registered. Ball/score updates land the clk after the tick that causes them.
- IDLE: ball held at the start position. start=1 on any clk clears scores, sets dir_x=1 and moves to SERVE.
- SERVE: ball held at the start position. The counter increments on each tick. On the tick where the counter reaches SERVE_TICKS-1, the counter clears and the state moves to PLAY. The ball does not move on that tick.
- PLAY: on each tick, with S=step and all comparisons 12-bit unsigned:
  - Vertical:
    - dir_y=0 and ball_y<=S: y=0, dir_y=1.
    - dir_y=1 and ball_y+BALL_SIZE+S>=SCREEN_H: y=SCREEN_H-BALL_SIZE, dir_y=0.
    - Otherwise y±=S.
  - Horizontal, using the pre-tick ball_y for paddle overlap. Overlap means ball_y+BALL_SIZE>paddle_y and ball_y<paddle_y+PADDLE_H.
    - Left hit: dir_x=0, ball_x>=P1_X+PADDLE_W, ball_x-S<=P1_X+PADDLE_W, overlap with paddle1 → x=P1_X+PADDLE_W, dir_x=1.
    - Right hit: dir_x=1, ball_x+BALL_SIZE<=P2_X, ball_x+BALL_SIZE+S>=P2_X, overlap with paddle2 → x=P2_X-BALL_SIZE, dir_x=0.
    - Else left miss: dir_x=0 and ball_x<S → player 2 scores.
    - Else right miss: dir_x=1 and ball_x+BALL_SIZE+S>SCREEN_W → player 1 scores.
    - Else x±=S.
  - Vertical and horizontal are resolved in the same tick. A paddle hit has priority over a miss. There is no collision from the paddle's back or sides.
  - On a score:
    - The scorer's count increments.
    - The matching point pulse fires for one clk.
    - Ball recentres, dir_x points toward the conceding player, dir_y is kept, step resets to BALL_STEP.
    - If the new score equals WIN_SCORE, go to DONE; otherwise go to SERVE.
- DONE: ball frozen, ticks ignored, scores held. start=1 clears scores and goes to SERVE with dir_x=1.
- start is ignored in SERVE and PLAY. Scores never wrap: WIN_SCORE must be 15 or less.

Optional Feature:
PONG_SPEEDUP_EN
- Defined: each paddle hit sets step=min(step+1, MAX_STEP). Step resets to BALL_STEP on reset and on every score.
- Undefined: step is constant BALL_STEP and there is no step register.

Test Plan:
- reset=0 asserted during PLAY with ball at (500,300) → outputs become (315,235), scores 0/0, state 00 before the next clk edge.
- start=1 for one clk in IDLE, tick every 4 clks → state 01. On the 60th tick state becomes 10. The first PLAY tick gives ball (317,237).
- paddle2_y=400 held after serve → tick 118 gives y=470 with dir up. Tick 148 gives x=610, y=410 with dir left.
- paddle2_y=0 held after serve → no right hit. Tick 158 sees ball_x=629: point_p1 pulses once, p1_score=1, ball (315,235), state 01, dir_x=1.
- p1_score=8 plus one more right miss → p1_score=9, state 11, ticks leave the ball unchanged. Then start=1 → scores 0/0, state 01.
- PONG_SPEEDUP_EN defined, paddle2_y=400 → after the right hit the step is 3 (x decreases 3 per tick). The next score restores step 2.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game sequencer.
// Owns ball position/velocity, wall and paddle collisions, scoring and the
// IDLE/SERVE/PLAY/DONE state machine. All outputs are registered.
// Optional build macro PONG_SPEEDUP_EN: each paddle hit raises the ball step
// by one, capped at MAX_STEP. Without it the step is the constant BALL_STEP.
module pong_game_ctrl #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned BALL_SIZE    = 10,
  parameter int unsigned PADDLE_W     = 10,
  parameter int unsigned PADDLE_H     = 50,
  parameter int unsigned P1_X         = 20,
  parameter int unsigned P2_X         = 620,
  parameter int unsigned BALL_START_X = 315,
  parameter int unsigned BALL_START_Y = 235,
  parameter int unsigned BALL_STEP    = 2,
  parameter int unsigned MAX_STEP     = 6,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_TICKS  = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [9:0]  paddle1_y,
  input  logic [9:0]  paddle2_y,
  output logic [10:0] ball_x,
  output logic [9:0]  ball_y,
  output logic [3:0]  p1_score,
  output logic [3:0]  p2_score,
  output logic [1:0]  state,
  output logic        point_p1,
  output logic        point_p2
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    DONE  = 2'b11
  } game_t;

  localparam int unsigned CNT_W = $clog2(SERVE_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [10:0] X_START = 11'(BALL_START_X);
  localparam logic [9:0]  Y_START = 10'(BALL_START_Y);
  localparam logic [9:0]  Y_FLOOR = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_P1HIT = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] X_P2HIT = 11'(P2_X - BALL_SIZE);
  localparam logic [11:0] C_BSZ   = 12'(BALL_SIZE);
  localparam logic [11:0] C_PH    = 12'(PADDLE_H);
  localparam logic [11:0] C_SW    = 12'(SCREEN_W);
  localparam logic [11:0] C_SH    = 12'(SCREEN_H);
  localparam logic [11:0] C_P1E   = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] C_P2X   = 12'(P2_X);
  localparam logic [3:0]  C_WIN   = 4'(WIN_SCORE);

  game_t             game_q, game_d;
  logic [10:0]       x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              dir_x_q, dir_x_d;
  logic              dir_y_q, dir_y_d;
  logic [3:0]        s1_q, s1_d;
  logic [3:0]        s2_q, s2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pp1_q, pp1_d;
  logic              pp2_q, pp2_d;
  logic [11:0]       step;

`ifdef PONG_SPEEDUP_EN
  localparam logic [3:0] C_STEP0 = 4'(BALL_STEP);
  localparam logic [3:0] C_SMAX  = 4'(MAX_STEP);
  logic [3:0]        step_q, step_d;
  logic [3:0]        step_bump;
  assign step      = {8'b0, step_q};
  assign step_bump = (step_q >= C_SMAX) ? C_SMAX : step_q + 4'd1;
`else
  assign step = 12'(BALL_STEP);
`endif

  // 12-bit views so all collision arithmetic is unsigned and overflow-free
  logic [11:0] bx, by, pa, pb;
  logic        ov1, ov2, hit_l, hit_r, miss_l, miss_r, top, bot;

  assign bx = {1'b0, x_q};
  assign by = {2'b00, y_q};
  assign pa = {2'b00, paddle1_y};
  assign pb = {2'b00, paddle2_y};

  assign ov1    = (by + C_BSZ > pa) && (by < pa + C_PH);
  assign ov2    = (by + C_BSZ > pb) && (by < pb + C_PH);
  assign hit_l  = !dir_x_q && (bx >= C_P1E) && (bx - step <= C_P1E) && ov1;
  assign hit_r  = dir_x_q && (bx + C_BSZ <= C_P2X) && (bx + C_BSZ + step >= C_P2X) && ov2;
  assign miss_l = !dir_x_q && (bx < step);
  assign miss_r = dir_x_q && (bx + C_BSZ + step > C_SW);
  assign top    = !dir_y_q && (by <= step);
  assign bot    = dir_y_q && (by + C_BSZ + step >= C_SH);

  // Next-state and next-datapath values for one clk
  always_comb begin
    game_d  = game_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;
    pp1_d   = 1'b0;
    pp2_d   = 1'b0;
`ifdef PONG_SPEEDUP_EN
    step_d  = step_q;
`endif
    case (game_q)
      IDLE, DONE: begin
        if (start) begin
          s1_d    = '0;
          s2_d    = '0;
          dir_x_d = 1'b1;
          x_d     = X_START;
          y_d     = Y_START;
          cnt_d   = '0;
          game_d  = SERVE;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            game_d = PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (top) begin
            y_d     = '0;
            dir_y_d = 1'b1;
          end else if (bot) begin
            y_d     = Y_FLOOR;
            dir_y_d = 1'b0;
          end else if (dir_y_q) begin
            y_d = 10'(by + step);
          end else begin
            y_d = 10'(by - step);
          end

          // Hits are tested before misses so a paddle save always wins
          if (hit_l) begin
            x_d     = X_P1HIT;
            dir_x_d = 1'b1;
`ifdef PONG_SPEEDUP_EN
            step_d  = step_bump;
`endif
          end else if (hit_r) begin
            x_d     = X_P2HIT;
            dir_x_d = 1'b0;
`ifdef PONG_SPEEDUP_EN
            step_d  = step_bump;
`endif
          end else if (miss_l) begin
            s2_d    = s2_q + 4'd1;
            pp2_d   = 1'b1;
            dir_x_d = 1'b0;
            x_d     = X_START;
            y_d     = Y_START;
`ifdef PONG_SPEEDUP_EN
            step_d  = C_STEP0;
`endif
            game_d  = (s2_q + 4'd1 == C_WIN) ? DONE : SERVE;
          end else if (miss_r) begin
            s1_d    = s1_q + 4'd1;
            pp1_d   = 1'b1;
            dir_x_d = 1'b1;
            x_d     = X_START;
            y_d     = Y_START;
`ifdef PONG_SPEEDUP_EN
            step_d  = C_STEP0;
`endif
            game_d  = (s1_q + 4'd1 == C_WIN) ? DONE : SERVE;
          end else if (dir_x_q) begin
            x_d = 11'(bx + step);
          end else begin
            x_d = 11'(bx - step);
          end
        end
      end
      default: game_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_q  <= IDLE;
      x_q     <= X_START;
      y_q     <= Y_START;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      pp1_q   <= 1'b0;
      pp2_q   <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      step_q  <= C_STEP0;
`endif
    end else begin
      game_q  <= game_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      pp1_q   <= pp1_d;
      pp2_q   <= pp2_d;
`ifdef PONG_SPEEDUP_EN
      step_q  <= step_d;
`endif
    end
  end

  assign ball_x   = x_q;
  assign ball_y   = y_q;
  assign p1_score = s1_q;
  assign p2_score = s2_q;
  assign state    = game_q;
  assign point_p1 = pp1_q;
  assign point_p2 = pp2_q;

endmodule
